// File: rtl/fbuf_capture_ctrl.sv
// Frame-level sequencer for the framebuffer write path: arms on request, aligns to
// VSYNC, flushes the write pointer, gates capture and checks each frame's integrity.
module fbuf_capture_ctrl #(
   parameter int FRAME_PIXELS = 230400,
   parameter int FLUSH_CYCLES = 2,
   parameter int FCNT_W       = 8
) (
   input  logic                            i_clk,
   input  logic                            i_rstn,
   input  logic                            i_start,
   input  logic                            i_continuous,
   input  logic                            i_abort,
   input  logic                            i_clr_err,
   input  logic                            i_vsync,
   input  logic                            i_fbuf_wr,
   input  logic [$clog2(FRAME_PIXELS)-1:0] i_fbuf_waddr,
   output logic                            o_flush,
   output logic                            o_capture_en,
   output logic                            o_busy,
   output logic                            o_frame_done,
   output logic [FCNT_W-1:0]               o_frame_cnt,
   output logic                            o_err_short,
   output logic                            o_err_long,
   output logic                            o_err_addr
);

   localparam int PW = $clog2(FRAME_PIXELS + 2);
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [PW-1:0] PIX_FULL   = PW'(FRAME_PIXELS);
   localparam logic [PW-1:0] PIX_SAT    = PW'(FRAME_PIXELS + 1);
   localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_VS,
      S_FLUSH,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t        state, nxt_state;
   logic          vsync_q;
   logic [PW-1:0] pix_cnt;
   logic [PW-1:0] pix_nxt;
   logic [FW-1:0] flush_cnt;
   logic          frame_err;
   logic          flush_d, cap_en_d, busy_d;

   logic vs_rise, abort_act, wr_cap, addr_bad, long_bad, short_bad;
   logic frame_end, good_frame;

   assign vs_rise   = i_vsync & ~vsync_q;
   assign abort_act = i_abort & (state != S_IDLE);
   assign wr_cap    = i_fbuf_wr & (state == S_CAPTURE);
   assign addr_bad  = wr_cap & (pix_cnt < PIX_FULL) & (PW'(i_fbuf_waddr) != pix_cnt);
   assign long_bad  = wr_cap & (pix_cnt >= PIX_FULL);
   assign pix_nxt   = (wr_cap && pix_cnt != PIX_SAT) ? pix_cnt + PW'(1) : pix_cnt;

   // The write landing in the closing VSYNC cycle is counted before the short check.
   assign frame_end  = (state == S_CAPTURE) & vs_rise & ~abort_act;
   assign short_bad  = frame_end & (pix_nxt < PIX_FULL);
   assign good_frame = frame_end & ~(frame_err | addr_bad | long_bad | short_bad);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; the reset here is synchronous because i_rstn is sampled on i_clk.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) state <= S_IDLE;
      else         state <= nxt_state;
   end

   // NOTE: nxt_state gets a default before the case so no path can infer a latch.
   always_comb begin
      nxt_state = state;
      unique case (state)
         S_IDLE:    if (i_start || i_continuous) nxt_state = S_WAIT_VS;
         S_WAIT_VS: if (vs_rise)                 nxt_state = S_FLUSH;
         S_FLUSH:   if (flush_cnt == '0)         nxt_state = S_CAPTURE;
         S_CAPTURE: if (vs_rise)                 nxt_state = S_DONE;
         S_DONE:    nxt_state = i_continuous ? S_FLUSH : S_IDLE;
         default:   nxt_state = S_IDLE;
      endcase
      if (abort_act) nxt_state = S_IDLE;
   end

   // Outputs are registered from the next state so they line up with the state itself.
   always_comb begin
      flush_d  = (nxt_state == S_FLUSH) | abort_act;
      cap_en_d = (nxt_state == S_CAPTURE);
      busy_d   = (nxt_state != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_flush      <= 1'b0;
         o_capture_en <= 1'b0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_cnt  <= '0;
      end else begin
         o_flush      <= flush_d;
         o_capture_en <= cap_en_d;
         o_busy       <= busy_d;
         o_frame_done <= good_frame;
         if (good_frame) o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
      end
   end

   // A high VSYNC across reset must not look like a fresh edge.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) vsync_q <= 1'b1;
      else         vsync_q <= i_vsync;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         flush_cnt <= '0;
      end else if (nxt_state == S_FLUSH && state != S_FLUSH) begin
         flush_cnt <= FLUSH_LOAD;
      end else if (state == S_FLUSH && flush_cnt != '0) begin
         flush_cnt <= flush_cnt - FW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         pix_cnt   <= '0;
         frame_err <= 1'b0;
      end else if (state == S_FLUSH) begin
         pix_cnt   <= '0;
         frame_err <= 1'b0;
      end else begin
         pix_cnt   <= pix_nxt;
         frame_err <= frame_err | addr_bad | long_bad | short_bad;
      end
   end

   // A new error wins over a coincident clear.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_err_short <= 1'b0;
         o_err_long  <= 1'b0;
         o_err_addr  <= 1'b0;
      end else begin
         o_err_short <= (o_err_short & ~i_clr_err) | short_bad;
         o_err_long  <= (o_err_long  & ~i_clr_err) | long_bad;
         o_err_addr  <= (o_err_addr  & ~i_clr_err) | addr_bad;
      end
   end

endmodule

// File: tb/tb_fbuf_capture_ctrl.sv
// Self-checking bench for fbuf_capture_ctrl with a frame-level reference model
// (write count, address faults, sticky flags, completed-frame count).
module tb_fbuf_capture_ctrl;

   localparam int NPIX = 16;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       i_start = 1'b0, i_continuous = 1'b0, i_abort = 1'b0, i_clr_err = 1'b0;
   logic       i_vsync = 1'b0, i_fbuf_wr = 1'b0;
   logic [3:0] i_fbuf_waddr = '0;
   logic       o_flush, o_capture_en, o_busy, o_frame_done;
   logic [7:0] o_frame_cnt;
   logic       o_err_short, o_err_long, o_err_addr;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int fr_n      = 0;
   bit fr_bad    = 1'b0;
   int exp_cnt   = 0;
   bit exp_short = 1'b0, exp_long = 1'b0, exp_addr = 1'b0;

   fbuf_capture_ctrl #(
      .FRAME_PIXELS(NPIX),
      .FLUSH_CYCLES(2),
      .FCNT_W      (8)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_start      (i_start),
      .i_continuous (i_continuous),
      .i_abort      (i_abort),
      .i_clr_err    (i_clr_err),
      .i_vsync      (i_vsync),
      .i_fbuf_wr    (i_fbuf_wr),
      .i_fbuf_waddr (i_fbuf_waddr),
      .o_flush      (o_flush),
      .o_capture_en (o_capture_en),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_frame_cnt  (o_frame_cnt),
      .o_err_short  (o_err_short),
      .o_err_long   (o_err_long),
      .o_err_addr   (o_err_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_errs(input string tag);
      check({tag, "_short"}, o_err_short, exp_short);
      check({tag, "_long"},  o_err_long,  exp_long);
      check({tag, "_addr"},  o_err_addr,  exp_addr);
   endtask

   task automatic vs_pulse();
      i_vsync = 1'b1;
      tick();
      i_vsync = 1'b0;
   endtask

   task automatic wait_capture();
      int nf  = 0;
      bit got = 1'b0;
      fr_n   = 0;
      fr_bad = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (o_capture_en) begin
            got = 1'b1;
            break;
         end
         if (o_flush) nf++;
         tick();
      end
      check("capture_reached", got, 1);
      check("flush_width", nf, 2);
   endtask

   task automatic arm_single();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("busy_after_start", o_busy, 1);
      vs_pulse();
      wait_capture();
   endtask

   task automatic arm_cont();
      i_continuous = 1'b1;
      tick();
      check("busy_after_cont", o_busy, 1);
      vs_pulse();
      wait_capture();
   endtask

   // Writes continue the frame's address sequence; bad_idx (absolute) gets a wrong address.
   task automatic send_writes(input int n, input int bad_idx, input int gap_max, input bit clr_at_bad);
      int idx;
      int gap;
      for (int i = 0; i < n; i++) begin
         idx = fr_n;
         gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         repeat (gap) tick();
         i_fbuf_wr    = 1'b1;
         i_fbuf_waddr = (idx == bad_idx) ? 4'(idx + 1) : 4'(idx);
         i_clr_err    = clr_at_bad && (idx == bad_idx);
         tick();
         i_fbuf_wr = 1'b0;
         if (i_clr_err) begin
            exp_short = 1'b0;
            exp_long  = 1'b0;
            exp_addr  = 1'b0;
         end
         i_clr_err = 1'b0;
         fr_n++;
         if (idx == bad_idx && idx < NPIX) begin
            fr_bad   = 1'b1;
            exp_addr = 1'b1;
            check("err_addr_at_write", o_err_addr, 1);
         end
         if (fr_n == NPIX + 1) begin
            exp_long = 1'b1;
            check("err_long_at_write", o_err_long, 1);
         end
      end
   endtask

   task automatic end_frame(input bit cont_next);
      bit good;
      vs_pulse();
      good = (fr_n == NPIX) && !fr_bad;
      if (fr_n < NPIX) exp_short = 1'b1;
      if (good) exp_cnt = (exp_cnt + 1) % 256;
      check("frame_done", o_frame_done, good);
      check("frame_cnt", o_frame_cnt, exp_cnt);
      check_errs("end");
      check("cap_en_in_done", o_capture_en, 0);
      tick();
      check("done_pulse_end", o_frame_done, 0);
      if (cont_next) check("reflush_from_done", o_flush, 1);
      else           check("idle_after_done", o_busy, 0);
   endtask

   task automatic clr_err();
      i_clr_err = 1'b1;
      tick();
      i_clr_err = 1'b0;
      exp_short = 1'b0;
      exp_long  = 1'b0;
      exp_addr  = 1'b0;
      check_errs("clr");
   endtask

   initial begin
      int n, bad;

      // Reset with VSYNC held high: outputs clear, and no edge seen afterwards
      i_vsync = 1'b1;
      repeat (3) tick();
      rstn = 1'b1;
      tick();
      check("rst_flush", o_flush, 0);
      check("rst_cap_en", o_capture_en, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_frame_done, 0);
      check("rst_cnt", o_frame_cnt, 0);
      check_errs("rst");

      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (4) tick();
      check("wait_vs_busy", o_busy, 1);
      check("wait_vs_no_flush", o_flush, 0);
      i_vsync = 1'b0;
      tick();
      check("wait_vs_still", o_flush, 0);
      vs_pulse();
      wait_capture();
      send_writes(NPIX, -1, 0, 1'b0);
      end_frame(1'b0);

      // Continuous: three frames, dropped mid-frame 3
      arm_cont();
      send_writes(NPIX, -1, 1, 1'b0);
      end_frame(1'b1);
      wait_capture();
      send_writes(NPIX, -1, 1, 1'b0);
      end_frame(1'b1);
      wait_capture();
      send_writes(8, -1, 0, 1'b0);
      i_continuous = 1'b0;
      send_writes(8, -1, 0, 1'b0);
      end_frame(1'b0);

      // Short frame, then long frame, then clear
      arm_single();
      send_writes(12, -1, 1, 1'b0);
      end_frame(1'b0);
      arm_single();
      send_writes(NPIX + 1, -1, 1, 1'b0);
      end_frame(1'b0);
      clr_err();

      // Address fault on the third write, coincident with a clear
      arm_single();
      send_writes(NPIX, 2, 0, 1'b1);
      end_frame(1'b0);
      clr_err();

      // Abort after 8 writes
      arm_single();
      send_writes(8, -1, 0, 1'b0);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("abort_cap_en", o_capture_en, 0);
      check("abort_busy", o_busy, 0);
      check("abort_flush", o_flush, 1);
      check("abort_done", o_frame_done, 0);
      tick();
      check("abort_flush_end", o_flush, 0);
      check("abort_cnt", o_frame_cnt, exp_cnt);
      check_errs("abort");

      // Randomized single-shot frames
      for (int f = 0; f < 12; f++) begin
         case ($urandom_range(9, 0))
            0, 1, 2, 3, 4, 5: n = NPIX;
            6, 7:             n = int'($urandom_range(NPIX - 1, 10));
            default:          n = int'($urandom_range(NPIX + 2, NPIX + 1));
         endcase
         bad = ($urandom_range(3, 0) == 0) ?
               int'($urandom_range((n < NPIX) ? n - 1 : NPIX - 1, 0)) : -1;
         arm_single();
         send_writes(n, bad, 2, 1'b0);
         end_frame(1'b0);
         if ($urandom_range(1, 0) == 1) clr_err();
      end

      // Run the counter to 255, then wrap with a start pulse mid-capture
      arm_cont();
      while (exp_cnt != 254) begin
         send_writes(NPIX, -1, 0, 1'b0);
         end_frame(1'b1);
         wait_capture();
      end
      send_writes(NPIX, -1, 0, 1'b0);
      i_continuous = 1'b0;
      end_frame(1'b0);
      arm_single();
      send_writes(8, -1, 0, 1'b0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("start_ignored_cap", o_capture_en, 1);
      send_writes(8, -1, 0, 1'b0);
      end_frame(1'b0);
      repeat (2) tick();
      check("stay_idle", o_busy, 0);

      // Abort in IDLE does nothing
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("idle_abort_flush", o_flush, 0);
      check("idle_abort_busy", o_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fbuf_capture_ctrl.md
Name: fbuf_capture_ctrl

Overview:
- Frame-level sequencer for the framebuffer write path.
- Arms on a capture request and aligns to camera VSYNC.
- Pulses flush to reset the write pointer, then enables capture.
- Monitors the framebuffer write strobe and address, and reports frame completion and frame-integrity errors (short, long, address mismatch).
- Sits between the camera/FIFO front end and the framebuffer write interface; single-shot or continuous.

Parameters:
FRAME_PIXELS, 230400, expected pixel writes per frame (equals framebuffer depth)
FLUSH_CYCLES, 2, width of o_flush pulse in i_clk cycles (>=1)
FCNT_W, 8, width of frame counter

Ports:
i_clk  in  1  system clock
i_rstn  in  1  reset, synchronous, active-low
i_start  in  1  single-shot capture request (pulse; sampled only in IDLE)
i_continuous  in  1  level; capture every frame while high
i_abort  in  1  pulse; cancel any activity immediately
i_clr_err  in  1  pulse; clear sticky error flags
i_vsync  in  1  camera VSYNC, already synchronous to i_clk, active high
i_fbuf_wr  in  1  framebuffer write strobe
i_fbuf_waddr  in  $clog2(FRAME_PIXELS)  framebuffer write address
o_flush  out  1  write-path flush/pointer reset
o_capture_en  out  1  gates upstream FIFO writes
o_busy  out  1  high in any state except IDLE
o_frame_done  out  1  one-cycle pulse per completed frame
o_frame_cnt  out  FCNT_W  completed-frame counter, wraps
o_err_short  out  1  sticky: frame ended with fewer than FRAME_PIXELS writes
o_err_long  out  1  sticky: more than FRAME_PIXELS writes in a frame
o_err_addr  out  1  sticky: write address differed from expected sequence

Behaviour:
Reset (i_rstn=0 at posedge i_clk):
- All outputs 0; state IDLE; pixel and flush counters 0.
- vsync_q = 1, so a high i_vsync after reset produces no edge.

VSYNC edge:
- vs_rise = i_vsync & ~vsync_q, with vsync_q registered every cycle.

States:
- IDLE: o_busy=0, o_capture_en=0. i_start | i_continuous -> WAIT_VS.
- WAIT_VS: vs_rise -> FLUSH. Flush counter loads FLUSH_CYCLES-1.
- FLUSH:
  - o_flush=1, o_capture_en=0, pixel counter held at 0.
  - Counter decrements each cycle; exit to CAPTURE on the cycle it reads 0.
  - o_flush is high for exactly FLUSH_CYCLES cycles.
- CAPTURE:
  - o_capture_en=1.
  - Each i_fbuf_wr: if i_fbuf_waddr != pix_cnt (when pix_cnt<FRAME_PIXELS), set err_addr. Then increment pix_cnt, saturating at FRAME_PIXELS+1.
  - A write while pix_cnt==FRAME_PIXELS sets err_long.
  - vs_rise -> DONE, evaluated on that edge: pix_cnt<FRAME_PIXELS sets err_short.
  - An i_fbuf_wr in the vs_rise cycle is counted before evaluation.
- DONE (1 cycle):
  - o_frame_done=1 and o_frame_cnt+1, only if no error was set for this frame.
  - o_capture_en=0.
  - Next state: FLUSH if i_continuous=1 (the ending VSYNC starts the next frame; flush counter reloads), else IDLE.

Abort and error handling:
- i_abort, any non-IDLE state: next state IDLE. o_capture_en drops next cycle. o_flush pulses one cycle. No frame_done, no count increment.
- i_abort in IDLE: no effect.
- Errors are sticky. i_clr_err clears them. If a new error and i_clr_err coincide, the error is set.

Other boundaries:
- i_start while busy: ignored.
- i_continuous falling during CAPTURE: the current frame completes, then IDLE.
- pix_cnt width: $clog2(FRAME_PIXELS+2).
- o_frame_cnt wraps from 2^FCNT_W-1 to 0.
- Writes outside CAPTURE are ignored (not counted, no error).

Outputs are registered. o_flush, o_capture_en and o_busy reflect the current state. o_frame_done is registered from the DONE entry condition and aligned with the DONE state.

Test Plan (FRAME_PIXELS=16, FLUSH_CYCLES=2):
1. i_start; vs_rise; 16 writes, addr 0..15; vs_rise -> o_flush high exactly 2 cycles, one o_frame_done pulse, o_frame_cnt=1, no errors, back to IDLE with o_busy=0.
2. i_continuous=1 for 3 frames of 16 writes -> 3 frame_done pulses, o_frame_cnt=3, FLUSH re-entered directly from DONE each time. Drop i_continuous mid-frame 3 -> frame 3 completes, then IDLE.
3. Frame with 12 writes -> err_short=1, no frame_done, cnt unchanged. Frame with 17 writes -> err_long=1. i_clr_err -> both 0.
4. Writes with addr sequence 0,1,3,... -> err_addr=1 at the third write. Also assert i_clr_err in the same cycle as an error -> flag remains 1.
5. i_abort during CAPTURE after 8 writes -> next cycle IDLE, o_capture_en=0, one-cycle o_flush, no frame_done. i_vsync held high across reset -> no WAIT_VS exit until a fresh rising edge.
6. o_frame_cnt at 255 plus one good frame (FCNT_W=8) -> wraps to 0. i_start pulsed during CAPTURE -> ignored.
